// File: rtl/draw_pipelined_if.sv
// draw_pipelined_if
// Bundles everything that flows between the VGA timing/game-logic side and
// the pixel renderer: game control flags, frame/pixel timing, object
// positions, and the rendered colour coming back.
//   master : timing generator + game logic (drives pixels/objects, sinks colour)
//   slave  : renderer (sinks pixels/objects, drives colour)
interface draw_pipelined_if #(
  parameter int N_BRICKS = 6,
  parameter int COORD_W  = 9,
  parameter int PIX_W    = 10
);
  logic                         start;
  logic                         win;
  logic                         lose;
  logic                         frame_start;
  logic                         pixel_valid;
  logic [PIX_W-1:0]             pixel_x;
  logic [PIX_W-1:0]             pixel_y;
  logic [COORD_W-1:0]           ball_x;
  logic [COORD_W-1:0]           ball_y;
  logic [COORD_W-1:0]           paddle_x;
  logic [N_BRICKS*COORD_W-1:0]  brick_x;
  logic [N_BRICKS*COORD_W-1:0]  brick_y;
  logic [N_BRICKS-1:0]          bricks_exist;
  logic [N_BRICKS-1:0]          brick_hit;
  logic [7:0]                   color_out;
  logic                         color_valid;

  modport master (
    output start, win, lose, frame_start, pixel_valid, pixel_x, pixel_y,
           ball_x, ball_y, paddle_x, brick_x, brick_y, bricks_exist, brick_hit,
    input  color_out, color_valid
  );

  modport slave (
    input  start, win, lose, frame_start, pixel_valid, pixel_x, pixel_y,
           ball_x, ball_y, paddle_x, brick_x, brick_y, bricks_exist, brick_hit,
    output color_out, color_valid
  );
endinterface

// File: rtl/draw_pipelined.sv
// draw_pipelined
// Two-stage pixel renderer for the brick-breaker VGA path. Stage 1 turns the
// scanned coordinate and object positions into hit flags; stage 2 resolves
// them into an RRRGGGBB colour using the game state (IDLE/PLAY/LOSE/WIN),
// a blinking lose overlay, and per-brick destruction flash counters.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset
//   bus  - draw_pipelined_if slave: control flags, pixel timing, object
//          positions in; color_out / color_valid out (2-cycle latency)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | game not started; every pixel black
// PLAY  | normal scene drawing
// LOSE  | latched; playfield blinks red every BLINK_FRAMES frames
// WIN   | latched; playfield solid white
module draw_pipelined #(
  parameter int N_BRICKS     = 6,
  parameter int COORD_W      = 9,
  parameter int PIX_W        = 10,
  parameter int BALL_SIZE    = 20,
  parameter int PADDLE_W     = 74,
  parameter int PADDLE_Y0    = 458,
  parameter int PADDLE_Y1    = 477,
  parameter int BRICK_W      = 57,
  parameter int BRICK_H      = 19,
  parameter int WALL_L0      = 127,
  parameter int WALL_L1      = 134,
  parameter int WALL_R0      = 505,
  parameter int WALL_R1      = 511,
  parameter int FLASH_FRAMES = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              clk,
  input  logic              rst,
  draw_pipelined_if.slave   bus
);

  // One extra bit so that position + size can never wrap.
  localparam int CW = PIX_W + 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7:0] BLACK  = 8'h00;
  localparam logic [7:0] RED    = 8'hE0;
  localparam logic [7:0] WHITE  = 8'hFF;
  localparam logic [7:0] YELLOW = 8'hFC;

  typedef enum logic [1:0] {IDLE, PLAY, LOSE, WIN} state_t;

  function automatic logic in_span(input logic [CW-1:0] p,
                                   input logic [CW-1:0] lo,
                                   input logic [CW-1:0] len);
    return (p >= lo) && (p < lo + len);
  endfunction

  state_t           state_q, state_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic [FW-1:0]    flash_cnt_q [N_BRICKS];
  logic [FW-1:0]    flash_cnt_d [N_BRICKS];
  logic [N_BRICKS-1:0] flashing;

  logic ball_s1_q,   ball_s1_d;
  logic paddle_s1_q, paddle_s1_d;
  logic brick_s1_q,  brick_s1_d;
  logic flash_s1_q,  flash_s1_d;
  logic wall_s1_q,   wall_s1_d;
  logic field_s1_q,  field_s1_d;
  logic valid_s1_q,  valid_s1_d;

  logic [7:0] color_q, color_d;
  logic       color_valid_q, color_valid_d;

  logic [CW-1:0]       px, py;
  logic [N_BRICKS-1:0] brick_in;

  // Flash counters: a hit reload takes precedence over the frame decrement.
  always_comb begin
    for (int i = 0; i < N_BRICKS; i++) begin
      flash_cnt_d[i] = flash_cnt_q[i];
      flashing[i]    = (flash_cnt_q[i] != '0);
      if (bus.brick_hit[i]) begin
        flash_cnt_d[i] = FW'(FLASH_FRAMES);
      end else if (bus.frame_start && flash_cnt_q[i] != '0) begin
        flash_cnt_d[i] = flash_cnt_q[i] - 1'b1;
      end
    end
  end

  // Stage 1: hit tests.
  always_comb begin
    px = CW'(bus.pixel_x);
    py = CW'(bus.pixel_y);
    for (int i = 0; i < N_BRICKS; i++) begin
      brick_in[i] = in_span(px, CW'(bus.brick_x[i*COORD_W +: COORD_W]), CW'(BRICK_W)) &&
                    in_span(py, CW'(bus.brick_y[i*COORD_W +: COORD_W]), CW'(BRICK_H));
    end
    ball_s1_d   = in_span(px, CW'(bus.ball_x), CW'(BALL_SIZE)) &&
                  in_span(py, CW'(bus.ball_y), CW'(BALL_SIZE));
    paddle_s1_d = in_span(px, CW'(bus.paddle_x), CW'(PADDLE_W)) &&
                  (py >= CW'(PADDLE_Y0)) && (py <= CW'(PADDLE_Y1));
    brick_s1_d  = |(brick_in & bus.bricks_exist);
    flash_s1_d  = |(brick_in & flashing);
    wall_s1_d   = ((px >= CW'(WALL_L0)) && (px < CW'(WALL_L1))) ||
                  ((px >= CW'(WALL_R0)) && (px < CW'(WALL_R1)));
    field_s1_d  = (px >= CW'(WALL_L1)) && (px < CW'(WALL_R0));
    valid_s1_d  = bus.pixel_valid;
  end

  // Game state and lose-screen blink.
  always_comb begin
    state_d       = state_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (!bus.start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PLAY;
        PLAY:    if (bus.lose)     state_d = LOSE;
                 else if (bus.win) state_d = WIN;
        default: state_d = state_q;
      endcase
    end

    if (state_d == LOSE && state_q != LOSE) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (state_q == LOSE && bus.frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 2: colour resolution using the state registered this cycle.
  always_comb begin
    color_d       = BLACK;
    color_valid_d = valid_s1_q;
    if (!valid_s1_q || state_q == IDLE) begin
      color_d = BLACK;
    end else if (state_q == WIN && field_s1_q) begin
      color_d = WHITE;
    end else if (state_q == LOSE && blink_phase_q && field_s1_q) begin
      color_d = RED;
    end else if (ball_s1_q) begin
      color_d = RED;
    end else if (paddle_s1_q) begin
      color_d = WHITE;
    end else if (brick_s1_q) begin
      color_d = WHITE;
    end else if (flash_s1_q) begin
      color_d = YELLOW;
    end else if (wall_s1_q) begin
      color_d = WHITE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BRICKS; i++) flash_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_BRICKS; i++) flash_cnt_q[i] <= flash_cnt_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_s1_q     <= 1'b0;
      paddle_s1_q   <= 1'b0;
      brick_s1_q    <= 1'b0;
      flash_s1_q    <= 1'b0;
      wall_s1_q     <= 1'b0;
      field_s1_q    <= 1'b0;
      valid_s1_q    <= 1'b0;
      color_q       <= BLACK;
      color_valid_q <= 1'b0;
    end else begin
      ball_s1_q     <= ball_s1_d;
      paddle_s1_q   <= paddle_s1_d;
      brick_s1_q    <= brick_s1_d;
      flash_s1_q    <= flash_s1_d;
      wall_s1_q     <= wall_s1_d;
      field_s1_q    <= field_s1_d;
      valid_s1_q    <= valid_s1_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
    end
  end

  assign bus.color_out   = color_q;
  assign bus.color_valid = color_valid_q;

endmodule

// File: doc/draw_pipelined.md
# draw_pipelined

Parametrised, two-stage pipelined pixel renderer for the brick-breaker VGA path (640x480). It sits between the VGA timing generator and the DAC. Each cycle it takes the pixel coordinate being scanned, plus the game-object positions from the game logic, and produces an 8-bit RRRGGGBB colour. On top of plain drawing it adds a configurable brick count, a per-brick destruction flash, and a latched win/lose overlay with a blinking lose screen.

## Interface
Parameters:
- N_BRICKS, 6, number of bricks
- COORD_W, 9, width of object coordinates
- PIX_W, 10, width of pixel_x / pixel_y
- BALL_SIZE, 20, ball square side (px)
- PADDLE_W, 74, paddle width
- PADDLE_Y0 / PADDLE_Y1, 458 / 477, paddle rows, inclusive
- BRICK_W / BRICK_H, 57 / 19, brick size
- WALL_L0 / WALL_L1, 127 / 134, left wall columns [L0, L1)
- WALL_R0 / WALL_R1, 505 / 511, right wall columns [R0, R1)
- FLASH_FRAMES, 8, frames a destroyed brick flashes
- BLINK_FRAMES, 16, frames per lose-overlay blink phase

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  game running; low forces IDLE
- win  in  1  level-sensitive win flag
- lose  in  1  level-sensitive lose flag
- frame_start  in  1  one-cycle pulse at the start of each frame
- pixel_valid  in  1  pixel_x/pixel_y are in the active area
- pixel_x  in  PIX_W  current column
- pixel_y  in  PIX_W  current row
- ball_x, ball_y  in  COORD_W each  ball top-left corner
- paddle_x  in  COORD_W  paddle left edge
- brick_x  in  N_BRICKS*COORD_W  brick i occupies bits [i*COORD_W +: COORD_W]
- brick_y  in  N_BRICKS*COORD_W  same packing as brick_x
- bricks_exist  in  N_BRICKS  brick i is alive
- brick_hit  in  N_BRICKS  one-cycle pulse: brick i was just destroyed
- color_out  out  8  pixel colour
- color_valid  out  1  color_out corresponds to a valid pixel

## Operation
Colours: BLACK 8'h00, RED 8'hE0, WHITE 8'hFF, YELLOW 8'hFC.

Hit tests:
- All comparisons are done at PIX_W+1 bits, so `x + size` never wraps.
- An object at (ox, oy) with size (w, h) covers `ox <= px < ox+w` and `oy <= py < oy+h`.

Flash counters (one per brick, width clog2(FLASH_FRAMES+1)):
- A `brick_hit[i]` pulse loads counter i with FLASH_FRAMES.
- On `frame_start`, every nonzero counter decrements by 1.
- If `brick_hit[i]` and `frame_start` arrive in the same cycle, the load wins.
- Brick i is flashing while its counter is nonzero, whatever `bricks_exist[i]` says.

State machine (IDLE, PLAY, LOSE, WIN):
- IDLE -> PLAY when `start = 1`.
- PLAY -> LOSE when `lose = 1`. If `lose` and `win` are both 1, LOSE wins.
- PLAY -> WIN when `win = 1` and `lose = 0`.
- LOSE and WIN are latched: the flags are ignored once there.
- Any state -> IDLE when `start = 0`. This has priority over every other transition.

Blink logic:
- Entering LOSE clears blink_cnt to 0 and sets blink_phase to 1.
- In LOSE, on each `frame_start`, blink_cnt increments.
- When blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.

Colour priority at stage 2 (first match wins):
1. IDLE -> BLACK.
2. WIN and pixel inside the playfield [WALL_L1, WALL_R0) -> WHITE.
3. LOSE, blink_phase = 1, and pixel inside the playfield -> RED.
4. Ball -> RED.
5. Paddle -> WHITE.
6. Any brick with `bricks_exist[i] = 1` -> WHITE.
7. Any flashing brick -> YELLOW.
8. Either wall -> WHITE.
9. Otherwise -> BLACK.

Outside the playfield, WIN and LOSE fall through to the normal scene, so walls and ball stay visible.

## Timing
- Reset values: color_out = 0, color_valid = 0, state = IDLE, all flash counters = 0, blink_cnt = 0, blink_phase = 0, all pipeline registers = 0.
- Stage 1 registers the individual hit flags (ball, paddle, brick_any, flash_any, wall, in_field) and pixel_valid.
- Stage 2 registers color_out and color_valid.
- Latency is 2 cycles: inputs at cycle t appear on color_out/color_valid at t+2.
- Stage 2 uses the state and blink_phase registered at that cycle. A state change at cycle t therefore affects the outputs of cycle t+1.
- color_valid is the input pixel_valid delayed by 2 cycles in every state, including IDLE.
- color_out is BLACK whenever color_valid = 0.
- Object position inputs are sampled at stage 1 only.
- Reset asserted mid-frame clears everything immediately. After release, the first valid output appears 2 cycles after the first pixel_valid.

## Test plan
- Reset, start = 1, ball at (200,100), pixel (205,110) valid at cycle t -> color_out = 8'hE0 and color_valid = 1 at t+2. Pixel (220,110) -> 8'h00 (right edge is exclusive).
- Ball at (500,470) overlapping the right wall and paddle row, pixel (519,479) -> no wraparound: ball wins, 8'hE0. Pixel (640,479) with pixel_valid = 0 -> color_valid = 0, color_out = 0.
- N_BRICKS = 6, brick 3 at (300,50), bricks_exist[3] = 0, pulse brick_hit[3] -> pixel (310,55) is 8'hFC for exactly 8 frame_starts, then 8'h00. Pulse brick_hit[3] together with frame_start -> counter reads 8.
- start = 1, then assert lose and win in the same cycle -> state LOSE. Pixel (300,300) is 8'hE0 for 16 frames, then normal scene for 16 frames, repeating. Later deasserting lose leaves state LOSE.
- In WIN, pixel (300,300) -> 8'hFF and wall pixel (130,10) -> 8'hFF. Drop start -> every pixel is 8'h00 one cycle later, state IDLE.
- Assert rst mid-frame while in LOSE with a flash active -> outputs 0 immediately. After release with start = 1: state PLAY, no flash.
